// File: rtl/mfp_ahb_vga_text_render_pkg.sv
// mfp_ahb_vga_text_render_pkg: shared text-mode geometry, clear FSM encoding and glyph table
package mfp_ahb_vga_text_render_pkg;
    localparam int P_COLS = 80;
    localparam int P_ROWS = 30;
    localparam int RAM_DEPTH = P_COLS * P_ROWS;
    localparam logic [11:0] LAST_CELL = 12'(RAM_DEPTH - 1);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    // Built-in 8x16 glyph set: blank space, every other code a distinct row pattern
    function automatic logic [7:0] font_glyph(input logic [7:0] code, input logic [3:0] row);
        return (code == 8'h20) ? 8'h00 : code ^ {row, ~row};
    endfunction
endpackage

// File: rtl/mfp_vga_font_rom.sv
// mfp_vga_font_rom: 4096x8 glyph ROM addressed by {code,row}, one-cycle registered read
//   I_clk   clock
//   I_ce    read enable (pixel clock enable)
//   I_addr  {char code[7:0], glyph row[3:0]}
//   O_data  glyph row, MSB is the leftmost pixel
module mfp_vga_font_rom
    import mfp_ahb_vga_text_render_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_ce,
    input  logic [11:0] I_addr,
    output logic [7:0]  O_data
);
    logic [7:0] r_data;
    always_ff @(posedge I_clk)
        if (I_ce)
            r_data <= font_glyph(I_addr[11:4], I_addr[3:0]);
    assign O_data = r_data;
endmodule

// File: rtl/mfp_ahb_vga_text_render.sv
// mfp_ahb_vga_text_render: 80x30 text-mode pixel stage with hardware clear-screen engine
//   I_clk, I_rst_n            clock, async active-low reset
//   I_pix_ce                  advances the 3-stage pixel pipeline
//   I_x, I_y, I_de, I_hs, I_vs  coordinates and sync from the timing stage
//   I_wr_en, I_wr_addr, I_wr_data  CPU cell write (cell = row*80 + col)
//   I_clr                     clear-screen request, acted on at its rising edge
//   O_busy                    clear engine running
//   O_red, O_green, O_blue, O_hs, O_vs  VGA pins, sync aligned with RGB
module mfp_ahb_vga_text_render
    import mfp_ahb_vga_text_render_pkg::*;
#(
    parameter logic [11:0] P_FG_RGB   = 12'hFFF,
    parameter logic [11:0] P_BG_RGB   = 12'h000,
    parameter logic [7:0]  P_CLR_CHAR = 8'h20
)(
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_pix_ce,
    input  logic [9:0]  I_x,
    input  logic [8:0]  I_y,
    input  logic        I_de,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic        I_wr_en,
    input  logic [11:0] I_wr_addr,
    input  logic [7:0]  I_wr_data,
    input  logic        I_clr,
    output logic        O_busy,
    output logic [3:0]  O_red,
    output logic [3:0]  O_green,
    output logic [3:0]  O_blue,
    output logic        O_hs,
    output logic        O_vs
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_ptr;
    logic        r_clr_d;
    logic        w_clr_rise;
    logic        w_we;
    logic [11:0] w_waddr;
    logic [7:0]  w_wdata;
    logic [7:0]  r_ram [RAM_DEPTH];
    logic [11:0] w_cell;
    logic [7:0]  r_char;
    logic [2:0]  r1_x;
    logic [2:0]  r2_x;
    logic [3:0]  r1_y;
    logic        r1_de;
    logic        r2_de;
    logic        r1_hs;
    logic        r2_hs;
    logic        r1_vs;
    logic        r2_vs;
    logic [7:0]  w_glyph;
    logic [11:0] r_rgb;

    assign w_clr_rise = I_clr & ~r_clr_d;

    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_clr_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= (r_state == CLEAR) ? r_ptr + 12'd1 : 12'd0;
            r_clr_d <= I_clr;
        end

    always_comb
        w_state_nxt = (r_state == IDLE) ? (w_clr_rise ? CLEAR : IDLE)
                                        : ((r_ptr == LAST_CELL) ? IDLE : CLEAR);

    // A clear request in the same cycle as a CPU write wins; the write is lost
    always_comb begin
        O_busy  = r_state == CLEAR;
        w_we    = O_busy | (I_wr_en & ~w_clr_rise & (I_wr_addr <= LAST_CELL));
        w_waddr = O_busy ? r_ptr : I_wr_addr;
        w_wdata = O_busy ? P_CLR_CHAR : I_wr_data;
    end

    always_ff @(posedge I_clk)
        if (w_we)
            r_ram[w_waddr] <= w_wdata;

    // row*80 + col as row*64 + row*16 + col
    assign w_cell = 12'({I_y[8:4], 6'b0}) + 12'({I_y[8:4], 4'b0}) + 12'(I_x[9:3]);

    // Out-of-range addresses only occur with de=0, where the pixel is blanked anyway
    always_ff @(posedge I_clk)
        if (I_pix_ce)
            r_char <= r_ram[(w_cell <= LAST_CELL) ? w_cell : 12'd0];

    mfp_vga_font_rom u_font (
        .I_clk  (I_clk),
        .I_ce   (I_pix_ce),
        .I_addr ({r_char, r1_y}),
        .O_data (w_glyph)
    );

    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            r1_x  <= '0;
            r1_y  <= '0;
            r1_de <= 1'b0;
            r1_hs <= 1'b1;
            r1_vs <= 1'b1;
            r2_x  <= '0;
            r2_de <= 1'b0;
            r2_hs <= 1'b1;
            r2_vs <= 1'b1;
            r_rgb <= '0;
            O_hs  <= 1'b1;
            O_vs  <= 1'b1;
        end else if (I_pix_ce) begin
            r1_x  <= I_x[2:0];
            r1_y  <= I_y[3:0];
            r1_de <= I_de;
            r1_hs <= I_hs;
            r1_vs <= I_vs;
            r2_x  <= r1_x;
            r2_de <= r1_de;
            r2_hs <= r1_hs;
            r2_vs <= r1_vs;
            r_rgb <= r2_de ? (w_glyph[3'd7 - r2_x] ? P_FG_RGB : P_BG_RGB) : 12'h000;
            O_hs  <= r2_hs;
            O_vs  <= r2_vs;
        end

    assign {O_red, O_green, O_blue} = r_rgb;
endmodule

// File: tb/tb_mfp_ahb_vga_text_render.sv
// tb_mfp_ahb_vga_text_render: randomized self-checking bench against a cell/glyph reference model
module tb_mfp_ahb_vga_text_render;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        de = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clr = 1'b0;
    logic        busy;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        o_hs;
    logic        o_vs;

    typedef struct {
        bit          known;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   mem[2400];
    int   checks = 0;
    int   errors = 0;

    mfp_ahb_vga_text_render dut (
        .I_clk     (clk),
        .I_rst_n   (rst_n),
        .I_pix_ce  (pix_ce),
        .I_x       (x),
        .I_y       (y),
        .I_de      (de),
        .I_hs      (hs),
        .I_vs      (vs),
        .I_wr_en   (wr_en),
        .I_wr_addr (wr_addr),
        .I_wr_data (wr_data),
        .I_clr     (clr),
        .O_busy    (busy),
        .O_red     (red),
        .O_green   (green),
        .O_blue    (blue),
        .O_hs      (o_hs),
        .O_vs      (o_vs)
    );

    always #10 clk = ~clk;

    // Reference: which character covers pixel (px,py), its glyph row, and whether the pixel is lit
    function automatic exp_t model_pix(input int px, input int py, input int pde, input int phs, input int pvs);
        exp_t e;
        int   code;
        int   g;
        int   r;
        e.hs = phs[0];
        e.vs = pvs[0];
        e.known = 1;
        e.rgb = 12'h000;
        if (pde != 0) begin
            code = mem[(py / 16) * 80 + px / 8];
            r = py % 16;
            if (code < 0) e.known = 0;
            else begin
                g = (code == 32) ? 0 : (code ^ (r * 16 + (15 - r)));
                e.rgb = (((g >> (7 - px % 8)) & 1) != 0) ? 12'hFFF : 12'h000;
            end
        end
        return e;
    endfunction

    task automatic reset_pipe_model();
        q.delete();
        repeat (3) q.push_back('{1, 12'h000, 1'b1, 1'b1});
    endtask

    task automatic pix_step(input int px, input int py, input int pde, input int phs, input int pvs);
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({o_hs, o_vs} !== {e.hs, e.vs}) begin
            errors++;
            $display("FAIL sync: got hs=%b vs=%b expected hs=%b vs=%b", o_hs, o_vs, e.hs, e.vs);
        end
        if (e.known) begin
            checks++;
            if ({red, green, blue} !== e.rgb) begin
                errors++;
                $display("FAIL rgb: got %h expected %h", {red, green, blue}, e.rgb);
            end
        end
        x = 10'(px);
        y = 9'(py);
        de = pde[0];
        hs = phs[0];
        vs = pvs[0];
        pix_ce = 1'b1;
        q.push_back(model_pix(px, py, pde, phs, pvs));
        @(negedge clk);
        pix_ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic render_cell(input int c);
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 8; xx++)
                pix_step((c % 80) * 8 + xx, (c / 80) * 16 + yy, 1, $urandom_range(1), $urandom_range(1));
    endtask

    task automatic flush();
        repeat (3) pix_step(0, 0, 0, 1, 1);
    endtask

    task automatic cpu_write(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 12'(a);
        wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 2400) mem[a] = d;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, red, green, blue, o_hs, o_vs} !== {1'b0, 12'h000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset: got busy=%b rgb=%h hs=%b vs=%b expected 0 000 1 1", busy, {red, green, blue}, o_hs, o_vs);
        end
        rst_n = 1'b1;
        reset_pipe_model();
        @(negedge clk);
    endtask

    task automatic test_sync();
        int d;
        for (int i = 0; i < 300; i++) begin
            d = $urandom_range(1);
            pix_step($urandom_range(639), $urandom_range(479), d, $urandom_range(1), $urandom_range(1));
        end
    endtask

    task automatic test_glyph_a();
        cpu_write(0, 8'h41);
        render_cell(0);
        flush();
    endtask

    task automatic test_last_cell();
        cpu_write(2399, 8'h41);
        render_cell(2399);
        cpu_write(352, 8'h55);
        cpu_write(2400, 8'h99);
        cpu_write(4095, 8'h99);
        render_cell(352);
        render_cell(0);
        render_cell(2399);
        flush();
    endtask

    task automatic test_random_writes();
        int addrs[$];
        int a;
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(2399);
            addrs.push_back(a);
            cpu_write(a, $urandom_range(255));
        end
        for (int i = 0; i < 5; i++) render_cell(addrs[$urandom_range(15)]);
        flush();
    endtask

    task automatic test_clear();
        int n;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: busy=%b expected 0", busy);
        end
        clr = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            wr_en = (n < 100) ? 1'($urandom_range(1)) : 1'b0;
            wr_addr = 12'($urandom_range(2399));
            wr_data = 8'h77;
            clr = (n < 20 || (n >= 40 && n < 60)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        wr_en = 1'b0;
        clr = 1'b0;
        checks++;
        if (n != 2400) begin
            errors++;
            $display("FAIL clear_len: busy cycles %0d expected 2400", n);
        end
        for (int i = 0; i < 2400; i++) mem[i] = 32;
        render_cell(0);
        render_cell(5);
        render_cell(2399);
        for (int i = 0; i < 3; i++) render_cell($urandom_range(2399));
        flush();
    endtask

    task automatic test_clr_vs_write();
        int n;
        cpu_write(5, 8'h61);
        clr = 1'b1;
        wr_en = 1'b1;
        wr_addr = 12'd5;
        wr_data = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_wr_start: busy=%b expected 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        clr = 1'b0;
        checks++;
        if (n != 2400) begin
            errors++;
            $display("FAIL clr_wr_len: busy cycles %0d expected 2400", n);
        end
        for (int i = 0; i < 2400; i++) mem[i] = 32;
        render_cell(5);
        flush();
    endtask

    task automatic test_reset_mid_clear();
        int cells[6] = '{0, 500, 999, 1000, 1500, 2399};
        foreach (cells[i]) cpu_write(cells[i], 8'h5A);
        clr = 1'b1;
        repeat (1001) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy: busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_reset: busy=%b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_next: busy=%b expected 0", busy);
        end
        clr = 1'b0;
        rst_n = 1'b1;
        reset_pipe_model();
        for (int i = 0; i < 1000; i++) mem[i] = 32;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_idle: busy=%b expected 0", busy);
        end
        render_cell(0);
        render_cell(500);
        render_cell(999);
        render_cell(1000);
        render_cell(1500);
        render_cell(2399);
        flush();
    endtask

    initial begin
        for (int i = 0; i < 2400; i++) mem[i] = -1;
        test_reset();
        test_sync();
        test_glyph_a();
        test_last_cell();
        test_random_writes();
        test_clear();
        test_clr_vs_write();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
